// File: rtl/mnist_pkg.sv
// mnist_pkg: shared canvas geometry, pixel types and streamer FSM states
package mnist_pkg;
  localparam int IMG_DIM = 28;
  localparam int NUM_PIX = IMG_DIM * IMG_DIM;
  localparam int PIX_W = 16;
  localparam int OUT_W = 8;
  typedef logic [PIX_W-1:0] cell_t;
  typedef logic [OUT_W-1:0] pix_t;
  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, DONE} state_t;
endpackage

// File: rtl/pix_convert.sv
// pix_convert: combinational canvas cell to NN pixel conversion (saturate, optional binarize via CANVAS_STREAM_BINARIZE_EN); cell_i in, pix_o out
module pix_convert #(
  parameter int PIX_W = 16,
  parameter int OUT_W = 8
) (
  input  logic [PIX_W-1:0] cell_i,
  output logic [OUT_W-1:0] pix_o
);
  logic [OUT_W-1:0] conv;
  assign conv = |cell_i[PIX_W-1 -: 4] ? '1 : cell_i[PIX_W-5 -: OUT_W];
`ifdef CANVAS_STREAM_BINARIZE_EN
  assign pix_o = conv[OUT_W-1] ? '1 : '0;
`else
  assign pix_o = conv;
`endif
endmodule

// File: rtl/canvas_streamer.sv
// canvas_streamer: streams one IMG_DIM x IMG_DIM canvas row-major to the NN input; frame_clk/Reset (sync, active-high), start -> busy/done, rd_addr/rd_data canvas read, pix_data/pix_valid/pix_ready/pix_last stream; CANVAS_STREAM_BINARIZE_EN selects binarized pixels
module canvas_streamer #(
  parameter int IMG_DIM = 28,
  parameter int PIX_W = 16,
  parameter int OUT_W = 8
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             start,
  output logic             busy,
  output logic [9:0]       rd_addr,
  input  logic [PIX_W-1:0] rd_data,
  output logic [OUT_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             done
);
  import mnist_pkg::*;
  localparam logic [9:0] LAST = 10'(IMG_DIM * IMG_DIM - 1);
  state_t state_q, state_d;
  logic [9:0] idx_q, idx_d;
  logic [OUT_W-1:0] pix_q, pix_d, conv;
  pix_convert #(.PIX_W(PIX_W), .OUT_W(OUT_W)) u_conv (.cell_i(rd_data), .pix_o(conv));
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pix_q <= pix_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pix_d = pix_q;
    case (state_q)
      IDLE: begin
        state_d = start ? READ : IDLE;
        idx_d = '0;
      end
      READ: state_d = LATCH;
      LATCH: begin
        pix_d = conv;
        state_d = SEND;
      end
      SEND: if (pix_ready) begin
        state_d = idx_q == LAST ? DONE : READ;
        idx_d = idx_q == LAST ? idx_q : idx_q + 10'd1;
      end
      DONE: begin
        state_d = IDLE;
        idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE;
  assign rd_addr = idx_q;
  assign pix_data = pix_q;
  assign pix_valid = state_q == SEND;
  assign pix_last = pix_valid && idx_q == LAST;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_canvas_streamer.sv
// tb_canvas_streamer: randomized self-checking bench for canvas_streamer against a pixel-list reference model
module tb_canvas_streamer;
  import mnist_pkg::*;
  logic frame_clk = 0, Reset = 1, start = 0, pix_ready = 0;
  logic [15:0] rd_data;
  logic [9:0] rd_addr;
  logic [7:0] pix_data;
  logic busy, pix_valid, pix_last, done;
  int total = 0, bad = 0;
  logic [15:0] canvas [NUM_PIX];
  logic [7:0] got_pix [$];
  bit got_last [$];
  int done_cnt = 0, cyc = 0, last_cyc = -1, done_cyc = -1;
  canvas_streamer dut (.frame_clk(frame_clk), .Reset(Reset), .start(start), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .done(done));
  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) rd_data <= canvas[rd_addr];
  always @(negedge frame_clk) begin
    cyc++;
    if (!Reset && pix_valid && pix_ready) begin
      got_pix.push_back(pix_data);
      got_last.push_back(pix_last);
      if (pix_last) last_cyc = cyc;
    end
    if (!Reset && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  function automatic logic [7:0] ref_pix(input logic [15:0] c);
    int v;
    v = (c >= 16'h1000) ? 255 : (int'(c) / 16) % 256;
`ifdef CANVAS_STREAM_BINARIZE_EN
    v = (v >= 128) ? 255 : 0;
`endif
    return 8'(v);
  endfunction
  function automatic int frame_errs();
    int e;
    e = (got_pix.size() > NUM_PIX) ? got_pix.size() - NUM_PIX : NUM_PIX - got_pix.size();
    for (int i = 0; i < NUM_PIX && i < got_pix.size(); i++) begin
      if (got_pix[i] !== ref_pix(canvas[i])) e++;
      if (got_last[i] !== (i == NUM_PIX - 1)) e++;
    end
    return e;
  endfunction
  function automatic logic [7:0] got_at(input int i);
    return (i < got_pix.size()) ? got_pix[i] : 8'hxx;
  endfunction
  task automatic fill(input bit rnd);
    for (int i = 0; i < NUM_PIX; i++)
      canvas[i] = !rnd ? 16'h0 : ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF));
  endtask
  task automatic pulse_start();
    got_pix.delete();
    got_last.delete();
    done_cnt = 0;
    @(posedge frame_clk); #1 start = 1;
    @(posedge frame_clk); #1 start = 0;
  endtask
  task automatic drive_to_done(input bit rnd);
    for (int c = 0; c < 10000 && done_cnt == 0; c++) begin
      @(posedge frame_clk); #1;
      pix_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    total++;
    if (done_cnt == 0) begin bad++; $display("FAIL done_timeout: done never seen, required a done pulse"); end
  endtask
  task automatic test_reset();
    Reset = 1;
    repeat (3) @(posedge frame_clk);
    #1;
    total++;
    if ({busy, pix_valid, pix_last, done} !== 4'b0) begin bad++; $display("FAIL reset_flags: busy/valid/last/done=%b required 0000", {busy, pix_valid, pix_last, done}); end
    total++;
    if (rd_addr !== 10'd0) begin bad++; $display("FAIL reset_addr: got %0d required 0", rd_addr); end
    total++;
    if (pix_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h required 00", pix_data); end
    Reset = 0;
  endtask
  task automatic test_zero_canvas();
    fill(0);
    pix_ready = 1;
    pulse_start();
    drive_to_done(0);
    total++;
    if (frame_errs() != 0) begin bad++; $display("FAIL zero_frame: errors %0d count %0d required 0 errors 784 pixels", frame_errs(), got_pix.size()); end
    total++;
    if (done_cyc !== last_cyc + 1) begin bad++; $display("FAIL zero_done_timing: done at %0d required %0d", done_cyc, last_cyc + 1); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after: got %b required 0", busy); end
    repeat (2) @(posedge frame_clk);
    #1;
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_count: got %0d required 1", done_cnt); end
  endtask
  task automatic test_latency_frame();
    fill(1);
    canvas[0] = 16'h0AB0;
    canvas[1] = 16'h07F0;
    canvas[2] = 16'h0800;
    canvas[NUM_PIX-1] = 16'h3000;
    pix_ready = 1;
    pulse_start();
    total++;
    if ({busy, pix_valid, rd_addr} !== {1'b1, 1'b0, 10'd0}) begin bad++; $display("FAIL lat_n1: busy=%b valid=%b addr=%0d required 1 0 0", busy, pix_valid, rd_addr); end
    @(posedge frame_clk); #1;
    total++;
    if (pix_valid !== 1'b0) begin bad++; $display("FAIL lat_n2: valid=%b required 0", pix_valid); end
    @(posedge frame_clk); #1;
    total++;
    if ({pix_valid, pix_data} !== {1'b1, ref_pix(canvas[0])}) begin bad++; $display("FAIL lat_n3: valid=%b data=%h required 1 %h", pix_valid, pix_data, ref_pix(canvas[0])); end
    @(posedge frame_clk); #1;
    total++;
    if ({pix_valid, rd_addr} !== {1'b0, 10'd1}) begin bad++; $display("FAIL same_cycle_xfer: valid=%b addr=%0d required 0 1", pix_valid, rd_addr); end
    drive_to_done(1);
    total++;
    if (frame_errs() != 0) begin bad++; $display("FAIL rand_frame: errors %0d count %0d required 0 errors 784 pixels", frame_errs(), got_pix.size()); end
`ifdef CANVAS_STREAM_BINARIZE_EN
    total++;
    if ({got_at(0), got_at(1), got_at(2)} !== {8'hFF, 8'h00, 8'hFF}) begin bad++; $display("FAIL const_pixels: %h %h %h required ff 00 ff", got_at(0), got_at(1), got_at(2)); end
`else
    total++;
    if ({got_at(0), got_at(1), got_at(2)} !== {8'hAB, 8'h7F, 8'h80}) begin bad++; $display("FAIL const_pixels: %h %h %h required ab 7f 80", got_at(0), got_at(1), got_at(2)); end
`endif
    total++;
    if (got_at(NUM_PIX-1) !== 8'hFF) begin bad++; $display("FAIL saturate_last: got %h required ff", got_at(NUM_PIX-1)); end
  endtask
  task automatic test_stall();
    logic [7:0] hold;
    int errs = 0;
    fill(1);
    pix_ready = 1;
    pulse_start();
    for (int c = 0; c < 200 && !(pix_valid && rd_addr == 10'd5); c++) begin @(posedge frame_clk); #1; end
    pix_ready = 0;
    hold = pix_data;
    repeat (10) begin
      @(posedge frame_clk); #1;
      if (!pix_valid || pix_data !== hold || rd_addr !== 10'd5) errs++;
    end
    total++;
    if (errs != 0 || hold !== ref_pix(canvas[5]) || got_pix.size() != 5) begin bad++; $display("FAIL stall_hold: unstable %0d data %h sent %0d required 0 %h 5", errs, hold, got_pix.size(), ref_pix(canvas[5])); end
    drive_to_done(0);
    total++;
    if (frame_errs() != 0) begin bad++; $display("FAIL stall_frame: errors %0d count %0d required 0 errors 784 pixels", frame_errs(), got_pix.size()); end
  endtask
  task automatic test_restart_ignored();
    fill(1);
    pix_ready = 1;
    pulse_start();
    for (int c = 0; c < 1000 && !(pix_valid && rd_addr == 10'd100); c++) begin @(posedge frame_clk); #1; end
    start = 1;
    @(posedge frame_clk); #1 start = 0;
    total++;
    if (!busy || rd_addr < 10'd100) begin bad++; $display("FAIL restart_addr: busy=%b addr=%0d required 1 and >=100", busy, rd_addr); end
    drive_to_done(1);
    repeat (3) @(posedge frame_clk);
    #1;
    total++;
    if (frame_errs() != 0 || done_cnt != 1) begin bad++; $display("FAIL restart_frame: errors %0d done %0d required 0 1", frame_errs(), done_cnt); end
  endtask
  task automatic test_reset_mid();
    fill(1);
    pix_ready = 1;
    pulse_start();
    for (int c = 0; c < 3000 && rd_addr != 10'd400; c++) begin @(posedge frame_clk); #1; end
    Reset = 1;
    start = 1;
    @(posedge frame_clk); #1;
    total++;
    if ({busy, pix_valid, pix_last, done, rd_addr, pix_data} !== 22'h0) begin bad++; $display("FAIL midreset_outputs: %h required 0", {busy, pix_valid, pix_last, done, rd_addr, pix_data}); end
    Reset = 0;
    start = 0;
    repeat (3) @(posedge frame_clk);
    #1;
    total++;
    if (busy !== 1'b0 || done_cnt != 0) begin bad++; $display("FAIL midreset_abort: busy=%b done=%0d required 0 0", busy, done_cnt); end
    fill(1);
    pulse_start();
    total++;
    if ({busy, rd_addr} !== {1'b1, 10'd0}) begin bad++; $display("FAIL midreset_restart: busy=%b addr=%0d required 1 0", busy, rd_addr); end
    drive_to_done(1);
    total++;
    if (frame_errs() != 0) begin bad++; $display("FAIL midreset_frame: errors %0d count %0d required 0 errors 784 pixels", frame_errs(), got_pix.size()); end
  endtask
  initial begin
    fill(0);
    test_reset();
    test_zero_canvas();
    test_latency_frame();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
